// File: rtl/pwm_duty_ramp.sv
// Duty-cycle generator for a downstream PWM: automatic triangle ramp with a
// programmable step prescaler, or manual up/down stepping, both saturating.
module pwm_duty_ramp #(
    parameter int DUTY_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic              up,
    input  logic              down,
    input  logic [CNT_W-1:0]  step_period,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              step_tick
);

    localparam logic [DUTY_W-1:0] DUTY_MAX  = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
    localparam logic [DUTY_W-1:0] DUTY_ONE  = {{(DUTY_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_RAMP   = 2'd1,
        OP_MANUAL = 2'd2
    } op_e;

    logic [DUTY_W-1:0] duty_r;
    logic              dir_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              tick_r;

    logic [DUTY_W-1:0] duty_nxt_s;
    logic              dir_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              tick_nxt_s;
    logic [CNT_W-1:0]  step_last_s;
    op_e               op_s;

    // Operation select and terminal count; a zero period behaves like one.
    always_comb begin
        step_last_s = CNT_ZERO;
        op_s        = OP_HOLD;
        if (step_period == CNT_ZERO) begin
            step_last_s = CNT_ZERO;
        end else begin
            step_last_s = step_period - CNT_ONE;
        end
        if (!en) begin
            op_s = OP_HOLD;
        end else if (mode) begin
            op_s = OP_MANUAL;
        end else begin
            op_s = OP_RAMP;
        end
    end

    // Next-state logic; the >= compare lets a lowered period step at once.
    always_comb begin
        duty_nxt_s = duty_r;
        dir_nxt_s  = dir_r;
        cnt_nxt_s  = cnt_r;
        tick_nxt_s = 1'b0;
        case (op_s)
            OP_RAMP: begin
                if (cnt_r >= step_last_s) begin
                    cnt_nxt_s  = CNT_ZERO;
                    tick_nxt_s = 1'b1;
                    if (dir_r) begin
                        if (duty_r == DUTY_MAX) begin
                            dir_nxt_s  = 1'b0;
                            duty_nxt_s = DUTY_MAX - DUTY_ONE;
                        end else begin
                            duty_nxt_s = duty_r + DUTY_ONE;
                        end
                    end else begin
                        // Turn around at zero without dwelling there.
                        if (duty_r == DUTY_ZERO) begin
                            dir_nxt_s  = 1'b1;
                            duty_nxt_s = DUTY_ONE;
                        end else begin
                            duty_nxt_s = duty_r - DUTY_ONE;
                        end
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            OP_MANUAL: begin
                cnt_nxt_s = CNT_ZERO;
                if (up && !down) begin
                    if (duty_r != DUTY_MAX) begin
                        duty_nxt_s = duty_r + DUTY_ONE;
                    end else begin
                        duty_nxt_s = duty_r;
                    end
                end else if (down && !up) begin
                    if (duty_r != DUTY_ZERO) begin
                        duty_nxt_s = duty_r - DUTY_ONE;
                    end else begin
                        duty_nxt_s = duty_r;
                    end
                end else begin
                    duty_nxt_s = duty_r;
                end
            end
            default: begin
                duty_nxt_s = duty_r;
                dir_nxt_s  = dir_r;
                cnt_nxt_s  = cnt_r;
                tick_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_r <= DUTY_ZERO;
            dir_r  <= 1'b1;
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else begin
            duty_r <= duty_nxt_s;
            dir_r  <= dir_nxt_s;
            cnt_r  <= cnt_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

    assign duty      = duty_r;
    assign dir       = dir_r;
    assign step_tick = tick_r;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: a behavioural reference model fills a
// scoreboard each cycle, plus fixed spot values at the notable cycles.
module tb_pwm_duty_ramp;

    localparam int DUTY_W = 4;
    localparam int CNT_W  = 16;
    localparam int MAX    = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              mode;
    logic              up;
    logic              down;
    logic [CNT_W-1:0]  step_period;
    logic [DUTY_W-1:0] duty;
    logic              dir;
    logic              step_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int duty;
        int dir;
        int tick;
    } exp_t;
    exp_t sb[$];

    int m_duty;
    int m_dir;
    int m_cnt;

    pwm_duty_ramp #(.DUTY_W(DUTY_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .up         (up),
        .down       (down),
        .step_period(step_period),
        .duty       (duty),
        .dir        (dir),
        .step_tick  (step_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour for the edge about to happen, pushed as expectation.
    task automatic model_push();
        exp_t e;
        int   per;
        e.tick = 0;
        if (reset) begin
            m_duty = 0; m_dir = 1; m_cnt = 0;
        end else if (en && mode) begin
            m_cnt = 0;
            if (up && !down && m_duty < MAX) m_duty++;
            else if (down && !up && m_duty > 0) m_duty--;
        end else if (en) begin
            per = (step_period == 0) ? 1 : int'(step_period);
            if (m_cnt + 1 >= per) begin
                m_cnt  = 0;
                e.tick = 1;
                if (m_dir == 1) begin
                    if (m_duty == MAX) begin m_dir = 0; m_duty = MAX - 1; end
                    else m_duty++;
                end else begin
                    if (m_duty == 0) begin m_dir = 1; m_duty = 1; end
                    else m_duty--;
                end
            end else begin
                m_cnt++;
            end
        end
        e.duty = m_duty;
        e.dir  = m_dir;
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".duty"}, 32'(duty), e.duty);
        check({tag, ".dir"}, 32'(dir), e.dir);
        check({tag, ".tick"}, 32'(step_tick), e.tick);
    endtask

    initial begin
        int ticks;
        reset = 1'b1; en = 1'b0; mode = 1'b0; up = 1'b0; down = 1'b0;
        step_period = 16'd3;
        m_duty = 0; m_dir = 1; m_cnt = 0;
        step("reset");
        step("reset");
        check("reset.duty0", 32'(duty), 0);
        check("reset.dir1", 32'(dir), 1);
        check("reset.tick0", 32'(step_tick), 0);

        // Slow triangle, period 3.
        reset = 1'b0; en = 1'b1;
        ticks = 0;
        for (int c = 1; c <= 93; c++) begin
            step("ramp3");
            if (step_tick) ticks++;
            check("ramp3.tick_slot", 32'(step_tick), (c % 3 == 0) ? 1 : 0);
            if (c == 3)  check("ramp3.c3", 32'(duty), 1);
            if (c == 45) check("ramp3.c45", 32'(duty), 15);
            if (c == 48) begin
                check("ramp3.c48", 32'(duty), 14);
                check("ramp3.c48dir", 32'(dir), 0);
            end
            if (c == 90) check("ramp3.c90", 32'(duty), 0);
            if (c == 93) begin
                check("ramp3.c93", 32'(duty), 1);
                check("ramp3.c93dir", 32'(dir), 1);
            end
        end
        check("ramp3.ticks", ticks, 31);

        // Zero period steps every cycle.
        reset = 1'b1; step("rst0");
        reset = 1'b0; step_period = 16'd0;
        for (int c = 1; c <= 16; c++) begin
            step("ramp0");
            check("ramp0.duty", 32'(duty), (c <= 15) ? c : 14);
            check("ramp0.tick", 32'(step_tick), 1);
        end
        check("ramp0.dir", 32'(dir), 0);

        // Manual saturation at both ends.
        mode = 1'b1; up = 1'b1;
        for (int c = 0; c < 20; c++) step("man_up");
        check("man_up.sat", 32'(duty), 15);
        down = 1'b1;
        for (int c = 0; c < 3; c++) step("man_both");
        check("man_both.hold", 32'(duty), 15);
        up = 1'b0;
        for (int c = 0; c < 20; c++) step("man_dn");
        check("man_dn.sat", 32'(duty), 0);
        check("man_dn.dir", 32'(dir), 0);

        // Back to ramp: falling at zero turns around after eff_period cycles.
        down = 1'b0; mode = 1'b0; step_period = 16'd2;
        step("resume");
        check("resume.c1", 32'(duty), 0);
        step("resume");
        check("resume.c2", 32'(duty), 1);
        check("resume.c2dir", 32'(dir), 1);

        // Hold mid-count at duty 6; manual inputs must be ignored while disabled.
        reset = 1'b1; step_period = 16'd3; step("rst1");
        reset = 1'b0;
        for (int c = 0; c < 19; c++) step("pre_hold");
        check("pre_hold.duty", 32'(duty), 6);
        en = 1'b0; mode = 1'b1; up = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step("hold");
            check("hold.duty", 32'(duty), 6);
            check("hold.tick", 32'(step_tick), 0);
        end
        mode = 1'b0; up = 1'b0; en = 1'b1;
        step("unhold");
        check("unhold.c1", 32'(duty), 6);
        step("unhold");
        check("unhold.c2", 32'(duty), 7);
        check("unhold.c2tick", 32'(step_tick), 1);

        // Lowering the period mid-count steps on the next cycle.
        reset = 1'b1; step_period = 16'd100; step("rst2");
        reset = 1'b0;
        for (int c = 0; c < 50; c++) step("p100");
        check("p100.duty", 32'(duty), 0);
        step_period = 16'd5;
        step("p5");
        check("p5.first", 32'(duty), 1);
        check("p5.firsttick", 32'(step_tick), 1);
        for (int c = 1; c <= 5; c++) begin
            step("p5");
            check("p5.tick", 32'(step_tick), (c == 5) ? 1 : 0);
        end
        check("p5.second", 32'(duty), 2);

        // Reset in the falling half at duty 9.
        reset = 1'b1; step("rst3");
        reset = 1'b0; step_period = 16'd1;
        for (int c = 0; c < 21; c++) step("p1");
        check("p1.duty", 32'(duty), 9);
        check("p1.dir", 32'(dir), 0);
        reset = 1'b1; step("midrst");
        check("midrst.duty", 32'(duty), 0);
        check("midrst.dir", 32'(dir), 1);
        check("midrst.tick", 32'(step_tick), 0);
        reset = 1'b0; step_period = 16'd4;
        for (int c = 1; c <= 4; c++) begin
            step("post_rst");
            check("post_rst.duty", 32'(duty), (c == 4) ? 1 : 0);
            check("post_rst.tick", 32'(step_tick), (c == 4) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
